piece_queue: RTL



---
 rtl/tetris_pkg.sv | 60 ++++++
 rtl/piece_bag.sv | 74 +++++++
 rtl/piece_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece-id constants, the shape ROM, LFSR
// constants and small arithmetic helpers used by the piece queue, the
// game-step logic and the rotate stage.
//   shape_rom(id) : 4x4 row-major shape, index 0 = top-left cell.
//   wrap7(v)      : v mod 7 for v in 0..13.
//   popcount7(m)  : number of set bits in a 7-bit bag mask.
//   lfsr_step(s)  : one step of the 16-bit right-shift Galois LFSR.
package tetris_pkg;

  localparam int unsigned NUM_PIECES = 7;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_L = 3'd1;
  localparam logic [2:0] PIECE_J = 3'd2;
  localparam logic [2:0] PIECE_Z = 3'd3;
  localparam logic [2:0] PIECE_S = 3'd4;
  localparam logic [2:0] PIECE_T = 3'd5;
  localparam logic [2:0] PIECE_O = 3'd6;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } queue_state_e;

  // Literals are written left-to-right as cells 0..15, which matches the
  // ascending [0:15] range of the return value.
  function automatic logic [0:15] shape_rom(input logic [2:0] id);
    logic [0:15] shape;
    case (id)
      PIECE_I: shape = 16'b0100_0100_0100_0100;
      PIECE_L: shape = 16'b0000_0111_0100_0000;
      PIECE_J: shape = 16'b0000_1110_0010_0000;
      PIECE_Z: shape = 16'b0000_1100_0110_0000;
      PIECE_S: shape = 16'b0000_0110_1100_0000;
      PIECE_T: shape = 16'b0000_1110_0100_0000;
      PIECE_O: shape = 16'b0000_0110_0110_0000;
      default: shape = 16'b0000_0000_0000_0000;
    endcase
    return shape;
  endfunction

  function automatic logic [2:0] wrap7(input logic [3:0] v);
    return (v >= 4'd7) ? 3'(v - 4'd7) : v[2:0];
  endfunction

  function automatic logic [2:0] popcount7(input logic [6:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/piece_bag.sv
// 7-bag randomiser. Owns the free-running LFSR, the bag mask of undrawn
// pieces, the draw search and the remaining-piece count.
//   clk, rst_n : clock, asynchronous active-low reset
//   draw_en    : consume draw_id this cycle
//   restart    : refill the bag (LFSR keeps running)
//   draw_id    : piece that would be drawn this cycle (combinational)
//   bag_left   : pieces still undrawn in the current bag
module piece_bag
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       draw_en,
  input  logic       restart,
  output logic [2:0] draw_id,
  output logic [2:0] bag_left
);

  // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr_q;
  logic [6:0]  mask_q;
  logic [2:0]  bag_left_q;
  logic [2:0]  cand_s;
  logic [2:0]  idx_s;
  logic [2:0]  pick_s;
  logic        found_s;
  logic        hit_s;
  logic [6:0]  mask_clr_s;
  logic [6:0]  mask_d;

  // Draw search: first id still in the bag, scanning upward from the LFSR candidate.
  always_comb begin
    cand_s  = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    pick_s  = cand_s;
    found_s = 1'b0;
    idx_s   = 3'd0;
    hit_s   = 1'b0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      idx_s   = wrap7({1'b0, cand_s} + 4'(i));
      hit_s   = !found_s && mask_q[idx_s];
      pick_s  = hit_s ? idx_s : pick_s;
      found_s = found_s | hit_s;
    end
    mask_clr_s = mask_q & ~(7'b000_0001 << pick_s);
    // The last piece of a bag refills it on the same draw, so the mask is never empty.
    mask_d = (mask_clr_s == 7'h00) ? 7'h7F : mask_clr_s;
  end

  // LFSR advances every cycle; bag state changes only on restart or a draw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= SEED_EFF;
      mask_q     <= 7'h7F;
      bag_left_q <= 3'd7;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (restart) begin
        mask_q     <= 7'h7F;
        bag_left_q <= 3'd7;
      end else if (draw_en) begin
        mask_q     <= mask_d;
        bag_left_q <= popcount7(mask_d);
      end
    end
  end

  assign draw_id  = pick_s;
  assign bag_left = bag_left_q;

endmodule

// File: rtl/piece_queue.sv
// Next-piece queue for the game-step logic: a head piece plus a preview list,
// fed from a 7-bag randomiser and refilled one piece per take.
//   clk, rst_n  : clock, asynchronous active-low reset
//   take        : consume the head piece (ignored until piece_valid)
//   restart     : flush queue and bag for a new game (wins over take)
//   piece_valid : head entry valid
//   piece_id    : head piece id 0..6
//   piece_shape : head shape, cell 0 = top-left
//   preview_ids : preview entry k at bits [3k+2:3k], entry 0 next after head
//   bag_left    : pieces still undrawn in the current bag
module piece_queue
  import tetris_pkg::*;
#(
  parameter int unsigned PREVIEW_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       take,
  input  logic                       restart,
  output logic                       piece_valid,
  output logic [2:0]                 piece_id,
  output logic [0:15]                piece_shape,
  output logic [3*PREVIEW_DEPTH-1:0] preview_ids,
  output logic [2:0]                 bag_left
);

  localparam int unsigned DEPTH = PREVIEW_DEPTH + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  queue_state_e  state_q;
  logic [CW-1:0] count_q;
  logic [2:0]    slots_q [DEPTH];
  logic          valid_q;
  logic [0:15]   shape_q;
  logic          draw_en_s;
  logic [2:0]    draw_id_s;

  piece_bag #(
    .LFSR_SEED (LFSR_SEED)
  ) u_bag (
    .clk      (clk),
    .rst_n    (rst_n),
    .draw_en  (draw_en_s),
    .restart  (restart),
    .draw_id  (draw_id_s),
    .bag_left (bag_left)
  );

  // A draw is consumed on every FILL cycle and on each accepted take; never on restart.
  always_comb begin
    draw_en_s = 1'b0;
    if (restart) begin
      draw_en_s = 1'b0;
    end else begin
      case (state_q)
        ST_FILL:  draw_en_s = 1'b1;
        ST_READY: draw_en_s = take;
        default:  draw_en_s = 1'b0;
      endcase
    end
  end

  // Queue FSM: fill slots in order, then shift on take with the new draw at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      count_q <= '0;
      valid_q <= 1'b0;
      shape_q <= 16'h0000;
      for (int k = 0; k < int'(DEPTH); k++) begin
        slots_q[k] <= 3'd0;
      end
    end else if (restart) begin
      state_q <= ST_FILL;
      count_q <= '0;
      valid_q <= 1'b0;
      shape_q <= 16'h0000;
      for (int k = 0; k < int'(DEPTH); k++) begin
        slots_q[k] <= 3'd0;
      end
    end else begin
      case (state_q)
        ST_FILL: begin
          for (int k = 0; k < int'(DEPTH); k++) begin
            if (count_q == CW'(k)) begin
              slots_q[k] <= draw_id_s;
            end
          end
          // Shape tracks slot 0 so it is always in step with piece_id.
          if (count_q == '0) begin
            shape_q <= shape_rom(draw_id_s);
          end
          count_q <= count_q + CW'(1);
          if (count_q == CW'(DEPTH - 1)) begin
            state_q <= ST_READY;
            valid_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (take) begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
              slots_q[k] <= slots_q[k+1];
            end
            slots_q[DEPTH-1] <= draw_id_s;
            shape_q          <= shape_rom(slots_q[1]);
          end
        end
        default: begin
          state_q <= ST_FILL;
          count_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign piece_valid = valid_q;
  assign piece_id    = slots_q[0];
  assign piece_shape = shape_q;

  for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
    assign preview_ids[3*g +: 3] = slots_q[g+1];
  end

endmodule
